// File: rtl/chroma_key_pipe.sv
// chroma_key_pipe: 3-stage registered chroma keyer with frame-synchronous
// configuration shadowing and a per-frame keyed-pixel counter.
module chroma_key_pipe #(
  parameter int          DW         = 8,
  parameter int          PASS_W     = 24,
  parameter int          CNT_W      = 20,
  parameter int unsigned THRESH_DEF = 82906
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_r,
  input  logic [DW-1:0]     in_g,
  input  logic [DW-1:0]     in_b,
  input  logic              frame_start,
  input  logic [PASS_W-1:0] pass_in,
  input  logic              cfg_en,
  input  logic              cfg_sel,
  input  logic [1:0]        cfg_mode,
  input  logic [3*DW-1:0]   cfg_thresh,
  input  logic [DW-1:0]     cfg_bg_r,
  input  logic [DW-1:0]     cfg_bg_g,
  input  logic [DW-1:0]     cfg_bg_b,
  output logic              out_valid,
  output logic [DW-1:0]     out_r,
  output logic [DW-1:0]     out_g,
  output logic [DW-1:0]     out_b,
  output logic              key_hit,
  output logic [PASS_W-1:0] pass_thru,
  output logic [CNT_W-1:0]  key_count_last,
  output logic              count_valid
);

  localparam int MW = 3 * DW;
  localparam logic [MW-1:0] THRESH_INIT = MW'(THRESH_DEF);

  logic          r_sh_en, r_sh_sel;
  logic [1:0]    r_sh_mode;
  logic [MW-1:0] r_sh_thresh;
  logic [DW-1:0] r_sh_bg_r, r_sh_bg_g, r_sh_bg_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_en     <= 1'b0;
      r_sh_sel    <= 1'b0;
      r_sh_mode   <= 2'd0;
      r_sh_thresh <= THRESH_INIT;
      r_sh_bg_r   <= '0;
      r_sh_bg_g   <= '0;
      r_sh_bg_b   <= '0;
    end else if (frame_start) begin
      r_sh_en     <= cfg_en;
      r_sh_sel    <= cfg_sel;
      r_sh_mode   <= cfg_mode;
      r_sh_thresh <= cfg_thresh;
      r_sh_bg_r   <= cfg_bg_r;
      r_sh_bg_g   <= cfg_bg_g;
      r_sh_bg_b   <= cfg_bg_b;
    end
  end

  // The frame_start pixel must already see the new config, so bypass the shadow.
  logic          w_en, w_sel;
  logic [1:0]    w_mode;
  logic [MW-1:0] w_thresh;
  logic [DW-1:0] w_bg_r, w_bg_g, w_bg_b;
  logic [DW-1:0] w_d, w_a, w_c, w_da, w_dc;
  logic          w_dom;

  always_comb begin
    w_en     = frame_start ? cfg_en     : r_sh_en;
    w_sel    = frame_start ? cfg_sel    : r_sh_sel;
    w_mode   = frame_start ? cfg_mode   : r_sh_mode;
    w_thresh = frame_start ? cfg_thresh : r_sh_thresh;
    w_bg_r   = frame_start ? cfg_bg_r   : r_sh_bg_r;
    w_bg_g   = frame_start ? cfg_bg_g   : r_sh_bg_g;
    w_bg_b   = frame_start ? cfg_bg_b   : r_sh_bg_b;
    w_d      = w_sel ? in_b : in_g;
    w_a      = in_r;
    w_c      = w_sel ? in_g : in_b;
    w_dom    = (w_d > w_a) && (w_d > w_c);
    w_da     = w_d - w_a;
    w_dc     = w_d - w_c;
  end

  logic              r1_valid, r1_fs, r1_dom, r1_en;
  logic [PASS_W-1:0] r1_pass;
  logic [DW-1:0]     r1_r, r1_g, r1_b, r1_d, r1_da, r1_dc;
  logic [1:0]        r1_mode;
  logic [MW-1:0]     r1_thresh;
  logic [DW-1:0]     r1_bg_r, r1_bg_g, r1_bg_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r1_fs     <= 1'b0;
      r1_dom    <= 1'b0;
      r1_en     <= 1'b0;
      r1_pass   <= '0;
      r1_r      <= '0;
      r1_g      <= '0;
      r1_b      <= '0;
      r1_d      <= '0;
      r1_da     <= '0;
      r1_dc     <= '0;
      r1_mode   <= 2'd0;
      r1_thresh <= '0;
      r1_bg_r   <= '0;
      r1_bg_g   <= '0;
      r1_bg_b   <= '0;
    end else begin
      r1_valid  <= in_valid;
      r1_fs     <= frame_start;
      r1_dom    <= w_dom;
      r1_en     <= w_en;
      r1_pass   <= pass_in;
      r1_r      <= in_r;
      r1_g      <= in_g;
      r1_b      <= in_b;
      r1_d      <= w_d;
      r1_da     <= w_da;
      r1_dc     <= w_dc;
      r1_mode   <= w_mode;
      r1_thresh <= w_thresh;
      r1_bg_r   <= w_bg_r;
      r1_bg_g   <= w_bg_g;
      r1_bg_b   <= w_bg_b;
    end
  end

  logic              r2_valid, r2_fs, r2_dom, r2_en;
  logic [PASS_W-1:0] r2_pass;
  logic [DW-1:0]     r2_r, r2_g, r2_b, r2_dc;
  logic [2*DW-1:0]   r2_prod;
  logic [1:0]        r2_mode;
  logic [MW-1:0]     r2_thresh;
  logic [DW-1:0]     r2_bg_r, r2_bg_g, r2_bg_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_fs     <= 1'b0;
      r2_dom    <= 1'b0;
      r2_en     <= 1'b0;
      r2_pass   <= '0;
      r2_r      <= '0;
      r2_g      <= '0;
      r2_b      <= '0;
      r2_dc     <= '0;
      r2_prod   <= '0;
      r2_mode   <= 2'd0;
      r2_thresh <= '0;
      r2_bg_r   <= '0;
      r2_bg_g   <= '0;
      r2_bg_b   <= '0;
    end else begin
      r2_valid  <= r1_valid;
      r2_fs     <= r1_fs;
      r2_dom    <= r1_dom;
      r2_en     <= r1_en;
      r2_pass   <= r1_pass;
      r2_r      <= r1_r;
      r2_g      <= r1_g;
      r2_b      <= r1_b;
      r2_dc     <= r1_dc;
      r2_prod   <= {{DW{1'b0}}, r1_d} * {{DW{1'b0}}, r1_da};
      r2_mode   <= r1_mode;
      r2_thresh <= r1_thresh;
      r2_bg_r   <= r1_bg_r;
      r2_bg_g   <= r1_bg_g;
      r2_bg_b   <= r1_bg_b;
    end
  end

  logic [MW-1:0] w_metric;
  logic          w_hit;
  logic [DW-1:0] w_fill_r, w_fill_g, w_fill_b;

  always_comb begin
    w_metric = r2_dom ? ({{DW{1'b0}}, r2_prod} * {{2*DW{1'b0}}, r2_dc}) : '0;
    w_hit    = r2_valid & r2_en & (w_metric > r2_thresh);
    w_fill_r = '0;
    w_fill_g = '0;
    w_fill_b = '0;
    case (r2_mode)
      2'd1: begin
        w_fill_r = r2_bg_r;
        w_fill_g = r2_bg_g;
        w_fill_b = r2_bg_b;
      end
      2'd2: begin
        w_fill_r = '1;
        w_fill_b = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      key_hit   <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      pass_thru <= '0;
    end else begin
      out_valid <= r2_valid;
      key_hit   <= w_hit;
      out_r     <= w_hit ? w_fill_r : r2_r;
      out_g     <= w_hit ? w_fill_g : r2_g;
      out_b     <= w_hit ? w_fill_b : r2_b;
      pass_thru <= r2_pass;
    end
  end

  // Counter tracks the hit being registered this edge, so it stays in step with the outputs.
  logic [CNT_W-1:0] r_key_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_count    <= '0;
      key_count_last <= '0;
      count_valid    <= 1'b0;
    end else if (r2_fs) begin
      key_count_last <= r_key_count;
      r_key_count    <= {{(CNT_W-1){1'b0}}, w_hit};
      count_valid    <= 1'b1;
    end else begin
      count_valid <= 1'b0;
      if (w_hit && !(&r_key_count))
        r_key_count <= r_key_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_chroma_key_pipe.sv
// tb_chroma_key_pipe: directed self-checking bench for chroma_key_pipe,
// with a second narrow-counter instance for the saturation case.
module tb_chroma_key_pipe;

  logic        clk, rst_n, in_valid, frame_start;
  logic [7:0]  in_r, in_g, in_b;
  logic [23:0] pass_in;
  logic        cfg_en, cfg_sel;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_thresh;
  logic [7:0]  cfg_bg_r, cfg_bg_g, cfg_bg_b;

  logic        out_valid, key_hit, count_valid;
  logic [7:0]  out_r, out_g, out_b;
  logic [23:0] pass_thru;
  logic [19:0] key_count_last;

  logic        sat_out_valid, sat_key_hit, sat_count_valid;
  logic [7:0]  sat_out_r, sat_out_g, sat_out_b;
  logic [23:0] sat_pass_thru;
  logic [2:0]  sat_key_count_last;

  int total = 0;
  int bad   = 0;

  chroma_key_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .frame_start(frame_start), .pass_in(pass_in),
    .cfg_en(cfg_en), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .cfg_bg_r(cfg_bg_r), .cfg_bg_g(cfg_bg_g), .cfg_bg_b(cfg_bg_b),
    .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .key_hit(key_hit), .pass_thru(pass_thru),
    .key_count_last(key_count_last), .count_valid(count_valid)
  );

  chroma_key_pipe #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .frame_start(frame_start), .pass_in(pass_in),
    .cfg_en(cfg_en), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .cfg_bg_r(cfg_bg_r), .cfg_bg_g(cfg_bg_g), .cfg_bg_b(cfg_bg_b),
    .out_valid(sat_out_valid), .out_r(sat_out_r), .out_g(sat_out_g), .out_b(sat_out_b),
    .key_hit(sat_key_hit), .pass_thru(sat_pass_thru),
    .key_count_last(sat_key_count_last), .count_valid(sat_count_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic en, input logic sel, input logic [1:0] mode,
                         input logic [23:0] th, input logic [7:0] br, input logic [7:0] bg,
                         input logic [7:0] bb);
    cfg_en = en; cfg_sel = sel; cfg_mode = mode; cfg_thresh = th;
    cfg_bg_r = br; cfg_bg_g = bg; cfg_bg_b = bb;
  endtask

  task automatic load_cfg(input logic en, input logic sel, input logic [1:0] mode,
                          input logic [23:0] th, input logic [7:0] br, input logic [7:0] bg,
                          input logic [7:0] bb);
    set_cfg(en, sel, mode, th, br, bg, bb);
    frame_start = 1'b1;
    in_valid    = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  // One valid pixel followed by two bubbles; its result is on the outputs afterwards.
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    in_valid = 1'b1; in_r = r; in_g = g; in_b = b;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [59:0] got;
    rst_n = 1'b0;
    tick();
    tick();
    got = {out_valid, key_hit, out_r, out_g, out_b, pass_thru, count_valid};
    total++;
    if (got !== 60'd0) begin
      bad++; $display("[TB] FAIL reset_outputs got=%h exp=0", got);
    end
    total++;
    if (key_count_last !== 20'd0) begin
      bad++; $display("[TB] FAIL reset_count got=%0d exp=0", key_count_last);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_green();
    logic [25:0] got, exp;
    load_cfg(1'b1, 1'b0, 2'd0, 24'd82906, 8'd0, 8'd0, 8'd0);
    send(8'd0, 8'd100, 8'd0);
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b1, 8'd0, 8'd0, 8'd0};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL green_keyed got=%h exp=%h", got, exp);
    end
    send(8'd40, 8'd50, 8'd40);
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b0, 8'd40, 8'd50, 8'd40};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL green_pass got=%h exp=%h", got, exp);
    end
    tick();
    total++;
    if ({out_valid, key_hit} !== 2'b00) begin
      bad++; $display("[TB] FAIL bubble got=%b exp=00", {out_valid, key_hit});
    end
  endtask

  task automatic test_boundary();
    logic [25:0] got, exp;
    send(8'd100, 8'd100, 8'd0);
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b0, 8'd100, 8'd100, 8'd0};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL equal_chan got=%h exp=%h", got, exp);
    end
    send(8'd0, 8'd255, 8'd0);
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b1, 8'd0, 8'd0, 8'd0};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL max_metric got=%h exp=%h", got, exp);
    end
    load_cfg(1'b1, 1'b0, 2'd0, 24'd1000000, 8'd0, 8'd0, 8'd0);
    send(8'd0, 8'd100, 8'd0);
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b0, 8'd0, 8'd100, 8'd0};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL thresh_equal got=%h exp=%h", got, exp);
    end
    load_cfg(1'b1, 1'b0, 2'd0, 24'd999999, 8'd0, 8'd0, 8'd0);
    send(8'd0, 8'd100, 8'd0);
    total++;
    if (key_hit !== 1'b1) begin
      bad++; $display("[TB] FAIL thresh_below got=%b exp=1", key_hit);
    end
  endtask

  task automatic test_blue();
    logic [25:0] got, exp;
    load_cfg(1'b1, 1'b1, 2'd1, 24'd82906, 8'd10, 8'd20, 8'd30);
    send(8'd0, 8'd0, 8'd200);
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b1, 8'd10, 8'd20, 8'd30};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL blue_bg got=%h exp=%h", got, exp);
    end
    send(8'd0, 8'd200, 8'd0);
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b0, 8'd0, 8'd200, 8'd0};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL blue_green_pass got=%h exp=%h", got, exp);
    end
    load_cfg(1'b1, 1'b1, 2'd2, 24'd82906, 8'd10, 8'd20, 8'd30);
    send(8'd0, 8'd0, 8'd200);
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b1, 8'd255, 8'd0, 8'd255};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL highlight got=%h exp=%h", got, exp);
    end
    load_cfg(1'b1, 1'b1, 2'd3, 24'd82906, 8'd10, 8'd20, 8'd30);
    send(8'd0, 8'd0, 8'd200);
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b1, 8'd0, 8'd0, 8'd0};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL mode_reserved got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_shadow();
    logic [25:0] got, exp;
    load_cfg(1'b1, 1'b0, 2'd0, 24'd82906, 8'd0, 8'd0, 8'd0);
    cfg_thresh = 24'd2000000;
    send(8'd0, 8'd100, 8'd0);
    total++;
    if (key_hit !== 1'b1) begin
      bad++; $display("[TB] FAIL shadow_midframe got=%b exp=1", key_hit);
    end
    in_valid = 1'b1; in_r = 8'd0; in_g = 8'd100; in_b = 8'd0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    in_valid    = 1'b0;
    tick();
    total++;
    if ({out_valid, key_hit} !== 2'b11) begin
      bad++; $display("[TB] FAIL shadow_inflight got=%b exp=11", {out_valid, key_hit});
    end
    tick();
    got = {out_valid, key_hit, out_r, out_g, out_b};
    exp = {1'b1, 1'b0, 8'd0, 8'd100, 8'd0};
    total++;
    if (got !== exp) begin
      bad++; $display("[TB] FAIL shadow_new got=%h exp=%h", got, exp);
    end
    total++;
    if (count_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL shadow_fs_delay got=%b exp=1", count_valid);
    end
  endtask

  task automatic test_counter();
    bit v[13] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
    bit k[13] = '{1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
    load_cfg(1'b1, 1'b0, 2'd0, 24'd82906, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 13; i++) begin
      in_valid = v[i];
      in_r = k[i] ? 8'd0 : 8'd40;
      in_g = k[i] ? 8'd100 : 8'd50;
      in_b = k[i] ? 8'd0 : 8'd40;
      tick();
    end
    in_valid    = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    total++;
    if (count_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL cnt_early got=%b exp=0", count_valid);
    end
    tick();
    total++;
    if ({count_valid, key_count_last} !== {1'b1, 20'd4}) begin
      bad++; $display("[TB] FAIL cnt_latch got=%b/%0d exp=1/4", count_valid, key_count_last);
    end
    tick();
    total++;
    if ({count_valid, key_count_last} !== {1'b0, 20'd4}) begin
      bad++; $display("[TB] FAIL cnt_pulse got=%b/%0d exp=0/4", count_valid, key_count_last);
    end
  endtask

  task automatic test_saturate();
    load_cfg(1'b1, 1'b0, 2'd0, 24'd82906, 8'd0, 8'd0, 8'd0);
    in_r = 8'd0; in_g = 8'd100; in_b = 8'd0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid    = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    total++;
    if ({sat_count_valid, sat_key_count_last} !== {1'b1, 3'd7}) begin
      bad++; $display("[TB] FAIL sat_count got=%b/%0d exp=1/7", sat_count_valid, sat_key_count_last);
    end
    total++;
    if (key_count_last !== 20'd12) begin
      bad++; $display("[TB] FAIL wide_count got=%0d exp=12", key_count_last);
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1'b1, 1'b0, 2'd0, 24'd82906, 8'd0, 8'd0, 8'd0);
    frame_start = 1'b1; in_valid = 1'b1; in_r = 8'd0; in_g = 8'd100; in_b = 8'd0;
    tick();
    in_r = 8'd40; in_g = 8'd50; in_b = 8'd40;
    tick();
    frame_start = 1'b0; in_valid = 1'b0;
    tick();
    total++;
    if ({count_valid, key_count_last} !== {1'b1, 20'd0}) begin
      bad++; $display("[TB] FAIL b2b_first got=%b/%0d exp=1/0", count_valid, key_count_last);
    end
    tick();
    total++;
    if ({count_valid, key_count_last} !== {1'b1, 20'd1}) begin
      bad++; $display("[TB] FAIL b2b_second got=%b/%0d exp=1/1", count_valid, key_count_last);
    end
    tick();
    total++;
    if (count_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_end got=%b exp=0", count_valid);
    end
  endtask

  task automatic test_passthru();
    logic [23:0] vals[12];
    for (int i = 0; i < 12; i++) vals[i] = 24'($urandom);
    for (int i = 0; i < 12; i++) begin
      pass_in  = vals[i];
      in_valid = i[0];
      tick();
      if (i >= 2) begin
        total++;
        if (pass_thru !== vals[i-2]) begin
          bad++; $display("[TB] FAIL pass_delay got=%h exp=%h", pass_thru, vals[i-2]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [59:0] got;
    load_cfg(1'b1, 1'b0, 2'd0, 24'd82906, 8'd0, 8'd0, 8'd0);
    pass_in = 24'hABCDEF;
    in_valid = 1'b1; in_r = 8'd0; in_g = 8'd100; in_b = 8'd0;
    tick();
    tick();
    tick();
    total++;
    if ({out_valid, key_hit, pass_thru} !== {2'b11, 24'hABCDEF}) begin
      bad++; $display("[TB] FAIL pre_reset got=%b/%h exp=11/abcdef", {out_valid, key_hit}, pass_thru);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {out_valid, key_hit, out_r, out_g, out_b, pass_thru, count_valid};
    total++;
    if (got !== 60'd0 || key_count_last !== 20'd0) begin
      bad++; $display("[TB] FAIL async_reset got=%h/%0d exp=0/0", got, key_count_last);
    end
    in_valid = 1'b0;
    pass_in  = 24'h123456;
    rst_n    = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL post_reset_early got=%b exp=0", out_valid);
    end
    tick();
    got = {34'd0, out_valid, key_hit, out_r, out_g, out_b};
    total++;
    if (got !== {34'd0, 1'b1, 1'b0, 8'd0, 8'd100, 8'd0}) begin
      bad++; $display("[TB] FAIL post_reset_default got=%h exp=%h", got,
                      {34'd0, 1'b1, 1'b0, 8'd0, 8'd100, 8'd0});
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
    in_r = '0; in_g = '0; in_b = '0; pass_in = '0;
    set_cfg(1'b0, 1'b0, 2'd0, 24'd0, 8'd0, 8'd0, 8'd0);
    test_reset();
    test_green();
    test_boundary();
    test_blue();
    test_shadow();
    test_counter();
    test_saturate();
    test_back_to_back();
    test_passthru();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chroma_key_pipe.md
# chroma_key_pipe

Pipelined, parametrised chroma-key stage for the camera-to-VGA video path. It replaces the combinational green-screen keyer with a 3-stage registered datapath and adds selectable key colour (green/blue), programmable threshold, and replacement mode. Key configuration is frame-synchronous, and the block keeps a per-frame count of keyed pixels. It sits in the pixel stream between the demosaic/colour stage and the display output. Aligned sync/pass-through bits travel with the pixels.

## Interface
- `DW`, 8: bits per colour channel.
- `PASS_W`, 24: width of the side-band bus delayed alongside the pixel.
- `CNT_W`, 20: width of the keyed-pixel counters.
- `THRESH_DEF`, 82906 (0x143DA): threshold value loaded at reset.
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input pixel qualifier.
- `in_r`, `in_g`, `in_b` in DW each: input pixel.
- `frame_start` in 1: one-cycle pulse marking the first cycle of a frame. It is independent of `in_valid`.
- `pass_in` in PASS_W: side-band data.
- `cfg_en` in 1: keying enable.
- `cfg_sel` in 1: key colour, 0 = green, 1 = blue.
- `cfg_mode` in 2: 0 = black fill, 1 = background-colour fill, 2 = highlight (output `{2^DW-1, 0, 2^DW-1}` magenta), 3 = reserved, treated as 0.
- `cfg_thresh` in 3*DW: key threshold.
- `cfg_bg_r`, `cfg_bg_g`, `cfg_bg_b` in DW each: background fill colour.
- `out_valid` out 1: output qualifier.
- `out_r`, `out_g`, `out_b` out DW each: output pixel.
- `key_hit` out 1: the current output pixel was keyed.
- `pass_thru` out PASS_W: `pass_in` delayed 3 cycles.
- `key_count_last` out CNT_W: keyed-pixel count of the previous frame.
- `count_valid` out 1: one-cycle pulse when `key_count_last` updates.

## Operation
**Shadow configuration**
- All `cfg_*` inputs are copied to shadow registers only in a cycle where `frame_start` = 1.
- The pixel presented in that same cycle already uses the new values.
- Between frame starts, changes on `cfg_*` have no effect.

**Keying metric**
- The dominant channel d is g when `cfg_sel` = 0, and b when `cfg_sel` = 1. The other two channels are a and c.
- The metric m = d*(d-a)*(d-c), computed unsigned in 3*DW bits, when d > a and d > c. Otherwise m = 0.
- The maximum value is 255*255*255 = 16,581,375, which fits in 24 bits with no overflow.

**Key decision**
- hit = shadow_en & (m > shadow_thresh). The comparison is strict.
- When hit = 1, the output colour is the fill defined by `shadow_mode`.
- When hit = 0, the input colour passes unchanged.

**Pipeline stages**
- S1: register the pixel, compute the differences and the dominance flag.
- S2: compute d*(d-a), 2*DW bits.
- S3: multiply by (d-c), compare against the threshold, select the output colour.
- The shadow config used for a pixel is captured in S1 with that pixel and carried down the pipeline. A config change therefore never affects pixels already in flight.

**Valid and side-band handling**
- There is no backpressure. `in_valid` = 0 produces a bubble: `out_valid` = 0 and `key_hit` = 0 three cycles later.
- `pass_in` and `frame_start` are delayed 3 cycles regardless of `in_valid`.

**Keyed-pixel counter**
- The internal counter `key_count` increments on `out_valid & key_hit`. It saturates at 2^CNT_W-1.
- When the delayed frame_start reaches the output:
  - `key_count_last` <= `key_count`.
  - `key_count` <= (out_valid & key_hit) ? 1 : 0, because the output pixel in that cycle belongs to the new frame.
  - `count_valid` = 1 for that cycle.

**Reset** (asserted asynchronously at any time, including mid-frame)
- Pipeline is cleared and all outputs are 0.
- `key_count` and `key_count_last` are 0; `count_valid` is 0.
- Shadow registers: thresh = `THRESH_DEF`, en = 0, sel = 0, mode = 0, bg = 0.
- In-flight pixels are discarded. Release of reset is synchronous to `clk`.

## Timing
- Latency is 3 cycles from input to output, for all of: pixel, `in_valid`, `pass_in`, `frame_start`.
- Throughput is one pixel per clock.
- `key_count_last` and `count_valid` are registered. They update on the clock edge where the delayed frame_start appears at S3, i.e. input frame_start cycle + 3.
- Back-to-back `frame_start` pulses: each one latches a count, which may be 0 or 1.
- Outputs are fully registered. There is no combinational path from input to output.

## Test plan
- **Green key, default threshold, en = 1, sel = 0, mode = 0.**
  - Pixel (r,g,b) = (0,100,0): m = 1,000,000 → out (0,0,0), `key_hit` = 1, 3 cycles later.
  - Pixel (40,50,40): m = 5000 → passes unchanged, `key_hit` = 0.
- **Boundaries.**
  - (100,100,0): d = a, so m = 0 → pass.
  - `cfg_thresh` = 1,000,000 with (0,100,0): m equals the threshold → pass, because the compare is strict.
  - (0,255,0): m = 16,581,375 → keyed.
- **Blue key, sel = 1, mode = 1, bg = (10,20,30).**
  - (0,0,200): out (10,20,30).
  - (0,200,0): pass.
  - mode = 2 with (0,0,200): out (255,0,255).
- **Shadow timing.**
  - Change `cfg_thresh` mid-frame → no effect until the next `frame_start`.
  - At the next `frame_start`, the pixel in that cycle uses the new value.
  - Pixels already in flight keep the old value.
- **Counter.**
  - Frame of 10 valid pixels, 4 keyed, with 3 invalid bubbles mixed in. At the next `frame_start`+3: `key_count_last` = 4, `count_valid` pulses for 1 cycle, bubbles are not counted.
  - With CNT_W = 3 and 12 keyed pixels: `key_count_last` = 7 (saturated).
- **Reset mid-frame.**
  - Assert `rst_n` = 0 asynchronously with a full pipeline. All outputs go to 0 immediately and shadow registers return to defaults.
  - After release, first output appears 3 cycles after the first input. Keying is disabled (en = 0) until a `frame_start` loads a new config.
  - `pass_thru` equals `pass_in` delayed 3 cycles throughout.
